// File: rtl/input_route_unit.sv
// input_route_unit: drains the input FIFO, XY-routes head flits, locks the
// chosen output port for the whole packet (wormhole) and presents one flit at
// a time through a registered valid/ready output.
// Optional feature macro: ROUTE_CHECK_EN (drop stray body/tail flits in IDLE
// and count them on drop_count).
module input_route_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 4,
  parameter int ROUTER_X    = 0,
  parameter int ROUTER_Y    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [4:0]            out_valid,
  input  logic [4:0]            out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_port
`ifdef ROUTE_CHECK_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_TAIL   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_SOUTH = 3'd2;
  localparam logic [2:0] PORT_EAST  = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  localparam logic [COORD_WIDTH-1:0] HOME_X = COORD_WIDTH'(ROUTER_X);
  localparam logic [COORD_WIDTH-1:0] HOME_Y = COORD_WIDTH'(ROUTER_Y);

`ifdef ROUTE_CHECK_EN
  // Stray body/tail flits in IDLE are dropped, so only a head opens a packet.
  localparam logic BODY_OPENS_PACKET = 1'b0;
`else
  // Without checking, a body seen in IDLE is treated as a head and opens a packet.
  localparam logic BODY_OPENS_PACKET = 1'b1;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_r, state_next_s;
  logic [2:0]              lock_r, lock_next_s;
  logic                    valid_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [2:0]              port_r;

  logic [1:0]              flit_type_s;
  logic [COORD_WIDTH-1:0]  dest_x_s;
  logic [COORD_WIDTH-1:0]  dest_y_s;
  logic [2:0]              route_s;
  logic [2:0]              flit_port_s;
  logic                    ready_sel_s;
  logic                    drop_s;
  logic                    load_s;

  // Port index to one-hot valid vector; out-of-range indices select nothing.
  function automatic logic [4:0] port_onehot(input logic [2:0] port);
    case (port)
      3'd0:    port_onehot = 5'b00001;
      3'd1:    port_onehot = 5'b00010;
      3'd2:    port_onehot = 5'b00100;
      3'd3:    port_onehot = 5'b01000;
      3'd4:    port_onehot = 5'b10000;
      default: port_onehot = 5'b00000;
    endcase
  endfunction

  assign flit_type_s = fifo_dout[DATA_WIDTH-1 -: 2];
  assign dest_x_s    = fifo_dout[DATA_WIDTH-3 -: COORD_WIDTH];
  assign dest_y_s    = fifo_dout[DATA_WIDTH-3-COORD_WIDTH -: COORD_WIDTH];

  // Dimension-ordered XY route of the flit at the FIFO head.
  always_comb begin
    route_s = PORT_LOCAL;
    if (dest_x_s > HOME_X) begin
      route_s = PORT_EAST;
    end else if (dest_x_s < HOME_X) begin
      route_s = PORT_WEST;
    end else if (dest_y_s > HOME_Y) begin
      route_s = PORT_NORTH;
    end else if (dest_y_s < HOME_Y) begin
      route_s = PORT_SOUTH;
    end else begin
      route_s = PORT_LOCAL;
    end
  end

  // Only the ready bit of the port currently held in the register matters.
  assign ready_sel_s = |(port_onehot(port_r) & out_ready);

`ifdef ROUTE_CHECK_EN
  assign drop_s = ~fifo_empty & (state_r == IDLE) &
                  ((flit_type_s == TYPE_BODY) | (flit_type_s == TYPE_TAIL));
`else
  assign drop_s = 1'b0;
`endif

  assign load_s      = ~fifo_empty & ~drop_s & (~valid_r | ready_sel_s);
  assign fifo_rd_en  = (load_s | drop_s) & ~rst;
  assign flit_port_s = (state_r == IDLE) ? route_s : lock_r;

  // Packet lock FSM: advances only on flits that are loaded into the register.
  always_comb begin
    state_next_s = state_r;
    lock_next_s  = lock_r;
    if (load_s) begin
      case (state_r)
        IDLE: begin
          if ((flit_type_s == TYPE_HEAD) ||
              (BODY_OPENS_PACKET && (flit_type_s == TYPE_BODY))) begin
            state_next_s = BUSY;
            lock_next_s  = route_s;
          end else begin
            state_next_s = IDLE;
          end
        end
        BUSY: begin
          if ((flit_type_s == TYPE_TAIL) || (flit_type_s == TYPE_SINGLE)) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = BUSY;
          end
        end
        default: begin
          state_next_s = IDLE;
          lock_next_s  = 3'd0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM state and locked output port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lock_r  <= 3'd0;
    end else begin
      state_r <= state_next_s;
      lock_r  <= lock_next_s;
    end
  end

  // Output flit register: replaced on load, emptied on a handshake without load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      port_r  <= 3'd0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      data_r  <= fifo_dout;
      port_r  <= flit_port_s;
    end else if (valid_r && ready_sel_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef ROUTE_CHECK_EN
  logic [15:0] drop_count_r;

  // Saturating count of discarded stray flits.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_r <= 16'd0;
    end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'd1;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  assign drop_count = drop_count_r;
`endif

  assign out_data  = data_r;
  assign out_port  = port_r;
  assign out_valid = valid_r ? port_onehot(port_r) : 5'b00000;

endmodule

// File: tb/tb_input_route_unit.sv
// Scoreboard bench for input_route_unit at router (1,1): a packet-level model
// predicts every forwarded flit and its port when the flit enters the modelled
// FIFO; a monitor compares on every output handshake.
module tb_input_route_unit;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int RX = 1;
  localparam int RY = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_port;
`ifdef ROUTE_CHECK_EN
  logic [15:0]   drop_count;
`endif

  input_route_unit #(
    .DATA_WIDTH(DW), .COORD_WIDTH(CW), .ROUTER_X(RX), .ROUTER_Y(RY)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_port(out_port)
`ifdef ROUTE_CHECK_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    port;
  } exp_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            pop_now = 1'b0;
  bit            gap = 1'b0;
  logic [4:0]    ready_v = 5'b00000;
  logic          rst_v = 1'b1;
  bit            in_pkt = 1'b0;
  logic [2:0]    lock_port = 3'd0;
  int            drops_exp = 0;

  function automatic logic [2:0] ref_route(input int x, input int y);
    if (x > RX) return 3'd3;
    if (x < RX) return 3'd4;
    if (y > RY) return 3'd1;
    if (y < RY) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int x, input int y);
    logic [21:0] pay;
    pay = 22'($urandom);
    return {t, 4'(x), 4'(y), pay};
  endfunction

  // Push a flit into the modelled FIFO and predict what the router does with it.
  task automatic enqueue(input logic [DW-1:0] f);
    logic [1:0] t;
    logic [2:0] p;
    t = f[31:30];
    fifo_q.push_back(f);
    if (!in_pkt) begin
`ifdef ROUTE_CHECK_EN
      if (t == 2'b00 || t == 2'b10) begin
        drops_exp++;
        return;
      end
`endif
      p = ref_route(int'(f[29:26]), int'(f[25:22]));
      if (t == 2'b01 || t == 2'b00) begin
        in_pkt = 1'b1;
        lock_port = p;
      end
    end else begin
      p = lock_port;
      if (t == 2'b10 || t == 2'b11) in_pkt = 1'b0;
    end
    exp_q.push_back('{data: f, port: p});
  endtask

  task automatic gen_packet();
    int r, n;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      enqueue(mk($urandom_range(0, 1) ? 2'b00 : 2'b10, $urandom_range(0, 3), $urandom_range(0, 3)));
    end else if (r < 4) begin
      enqueue(mk(2'b11, $urandom_range(0, 3), $urandom_range(0, 3)));
    end else begin
      n = $urandom_range(0, 3);
      enqueue(mk(2'b01, $urandom_range(0, 3), $urandom_range(0, 3)));
      for (int i = 0; i < n; i++) begin
        enqueue(mk(($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00, $urandom_range(0, 3), $urandom_range(0, 3)));
      end
      enqueue(mk(2'b10, $urandom_range(0, 3), $urandom_range(0, 3)));
    end
  endtask

  // One clock: retire the previous pop, drive inputs after negedge, sample rd_en.
  task automatic cycle();
    @(negedge clk);
    if (pop_now) begin
      n_checks++;
      if (fifo_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_empty: rd_en=1 required 0 (fifo empty)");
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    rst = rst_v;
    out_ready = ready_v;
    fifo_empty = gap || (fifo_q.size() == 0);
    fifo_dout = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    #1;
    pop_now = fifo_rd_en;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    gap = 1'b0;
    ready_v = 5'b11111;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < 500) begin
      cycle();
      k++;
    end
    check("drain_timeout", (k >= 500) ? 32'd1 : 32'd0, 32'd0);
    cycle();
    cycle();
  endtask

  // Monitor: compare on handshakes, check one-hot valid and backpressure stability.
  logic [DW-1:0] prev_data;
  logic [2:0]    prev_port;
  logic [4:0]    prev_valid;
  bit            prev_hold = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (prev_hold) begin
      n_checks++;
      if (out_data !== prev_data || out_port !== prev_port || out_valid !== prev_valid) begin
        n_fail++;
        $display("FAIL hold: got %0h/%0d/%b required %0h/%0d/%b",
                 out_data, out_port, out_valid, prev_data, prev_port, prev_valid);
      end
    end
    if (out_valid !== 5'b00000) begin
      n_checks++;
      if (out_valid !== (5'b00001 << out_port)) begin
        n_fail++;
        $display("FAIL onehot: got %b required %b", out_valid, 5'b00001 << out_port);
      end
      if ((out_valid & out_ready) != 5'b00000 && !rst) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_flit: got %0h port %0d required none", out_data, out_port);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_port !== e.port) begin
            n_fail++;
            $display("FAIL flit: got %0h port %0d required %0h port %0d",
                     out_data, out_port, e.data, e.port);
          end
        end
      end
    end
    prev_hold = (out_valid != 5'b00000) && ((out_valid & out_ready) == 5'b00000) && !rst;
    prev_data = out_data;
    prev_port = out_port;
    prev_valid = out_valid;
  end

  initial begin
    rst = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout = '0;
    out_ready = 5'b00000;
    rst_v = 1'b1;
    cycle();
    cycle();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_port", 32'(out_port), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst_v = 1'b0;
    cycle();

    // Randomized traffic with FIFO gaps and random backpressure.
    for (int c = 0; c < 3000; c++) begin
      if (fifo_q.size() < 4) gen_packet();
      gap = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < 5; b++) ready_v[b] = ($urandom_range(0, 3) != 0);
      cycle();
    end
    if (in_pkt) enqueue(mk(2'b10, 0, 0));
    drain();

    // Back-to-back 3-flit packet east: rd_en on 3 cycles, valid one cycle later.
    enqueue(mk(2'b01, 2, 1));
    enqueue(mk(2'b00, 0, 0));
    enqueue(mk(2'b10, 0, 0));
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("tput_rd_en%0d", k), 32'(pop_now), (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("tput_valid%0d", k), 32'(out_valid), (k >= 1 && k <= 3) ? 32'h8 : 32'h0);
    end
    drain();

    // Reset while BUSY with a body held under backpressure.
    begin
      logic [DW-1:0] h, b1, b2, s;
      int k;
      h = mk(2'b01, 2, 1);
      b1 = mk(2'b00, 0, 0);
      b2 = mk(2'b00, 0, 0);
      s = mk(2'b11, 1, 0);
      fifo_q.push_back(h);
      fifo_q.push_back(b1);
      fifo_q.push_back(b2);
      exp_q.push_back('{data: h, port: 3'd3});
      exp_q.push_back('{data: b1, port: 3'd3});
      k = 0;
      do begin
        cycle();
        k++;
      end while (!(fifo_q.size() == 1 && pop_now) && k < 20);
      check("rstseq_timeout", (k >= 20) ? 32'd1 : 32'd0, 32'd0);
      ready_v = 5'b00000;
      fifo_q.push_back(s);
      cycle();
      check("bp_valid", 32'(out_valid), 32'h8);
      check("bp_data", out_data, b2);
      check("bp_rd_en", 32'(pop_now), 32'd0);
      rst_v = 1'b1;
      cycle();
      check("rst_rd_en_busy", 32'(pop_now), 32'd0);
      rst_v = 1'b0;
      ready_v = 5'b11111;
      in_pkt = 1'b0;
      exp_q.push_back('{data: s, port: 3'd2});
      cycle();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_pop", 32'(pop_now), 32'd1);
      cycle();
      check("post_rst_south", 32'(out_valid), 32'h4);
    end
    drain();

`ifdef ROUTE_CHECK_EN
    // Stray body in IDLE is popped even without ready and never forwarded.
    ready_v = 5'b00000;
    enqueue(mk(2'b00, 3, 3));
    cycle();
    check("drop_pop", 32'(pop_now), 32'd1);
    cycle();
    check("drop_valid", 32'(out_valid), 32'd0);
    check("drop_count", 32'(drop_count), 32'(drops_exp));
    drain();
    check("drop_count_final", 32'(drop_count), 32'(drops_exp));
`endif

    check("exp_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/input_route_unit.md
# input_route_unit

Input-port route and forward stage of a router: drains the input-port FIFO through its asynchronous-read interface, decodes XY destination from head flits, locks the selected output port for the packet (wormhole), and presents flits one at a time through a registered valid/ready output toward the crossbar/arbiter. It sits directly downstream of the input FIFO. It sustains one flit per cycle when the selected output is ready.

## Interface
- DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the flit type.
- COORD_WIDTH, 4, width of each destination coordinate field.
- ROUTER_X, 0, this router's X coordinate.
- ROUTER_Y, 0, this router's Y coordinate.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  pop request to FIFO; combinational.
- fifo_dout  input  DATA_WIDTH  FIFO head flit; combinational, valid while fifo_empty=0.
- out_valid  output  5  one-hot flit-valid per output port (0 local, 1 north, 2 south, 3 east, 4 west).
- out_ready  input  5  per-port ready from downstream.
- out_data  output  DATA_WIDTH  registered flit, shared by all ports.
- out_port  output  3  index of the port out_data is destined for.

## Operation
- Flit type: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).
- Head/single fields: dest X = [DATA_WIDTH-3 -: COORD_WIDTH], dest Y = next COORD_WIDTH bits below X. Coordinates are unsigned.
- XY routing on head/single:
  - dest X > ROUTER_X → east (3).
  - dest X < ROUTER_X → west (4).
  - Otherwise, dest Y > ROUTER_Y → north (1).
  - dest Y < ROUTER_Y → south (2).
  - Otherwise → local (0).
- FSM states:
  - IDLE: no packet locked. A loaded head moves to BUSY with lock_port = computed route. A loaded single stays IDLE.
  - BUSY: body/tail/head flits all take lock_port; head is not re-decoded. A loaded tail or single returns to IDLE.
- Output register: out_data and out_port hold one flit. out_valid = valid_reg ? onehot(out_port) : 0.
- load = ~fifo_empty & (~valid_reg | out_ready[out_port]). fifo_rd_en = load & ~rst.
- On load: out_data ← fifo_dout and out_port ← route, with valid_reg ← 1.
- If there is a handshake (valid_reg & out_ready[out_port]) and no load: valid_reg ← 0.
- out_ready bits for ports other than out_port are ignored.
- Reset values:
  - out_valid = 0, out_data = 0, out_port = 0.
  - state = IDLE, lock_port = 0.
  - drop_count = 0 when ROUTE_CHECK_EN is defined.
  - fifo_rd_en = 0 while rst.

## Timing
- Latency: a flit visible at fifo_dout in cycle t (register free) is on out_data/out_valid after edge t+1.
- Throughput: 1 flit/cycle with out_ready[out_port] held high; back-to-back loads with no bubble.
- Backpressure: out_ready[out_port]=0 holds out_data, out_port and out_valid stable. fifo_rd_en stays 0.
- FIFO empty: no pop; valid_reg clears after the pending handshake.
- Handshake and load in the same cycle: the register is replaced with no bubble, and the FSM advances on the new flit.
- Reset mid-packet: the lock is released, the held flit is discarded, and the FIFO contents are untouched. The next flit is treated in IDLE.

## Configuration
- ROUTE_CHECK_EN defined:
  - In IDLE, a body or tail flit at the FIFO head is popped (fifo_rd_en=1 when ~fifo_empty, regardless of out_ready) and discarded.
  - The output register is not loaded for that flit.
  - 16-bit output drop_count increments per drop and saturates at 16'hFFFF.
- ROUTE_CHECK_EN undefined:
  - Any flit arriving in IDLE is decoded as a head.
  - A body arriving in IDLE enters BUSY; a tail arriving in IDLE stays IDLE.
  - No drop_count port.

## Test plan
- Single flit 0xC0000000|dest(0,0) at ROUTER_X=ROUTER_Y=0, out_ready=5'b11111 → out_valid=5'b00001 one cycle after the pop, out_port=0, state IDLE.
- 3-flit packet (head dest (2,0), body, tail) at router (1,1), out_ready[3]=1 → out_valid=5'b01000 on 3 consecutive cycles, fifo_rd_en high 3 consecutive cycles, ending in IDLE.
- Same packet with out_ready[3] low for 4 cycles after the head is loaded → out_data holds the head, fifo_rd_en=0 throughout; the body appears in the cycle after ready rises.
- Head dest (1,3) at router (1,1), then a packet to (0,1) → first packet north (1), second west (4); ports are never interleaved within a packet.
- Reset asserted while BUSY after the body → out_valid=0 next cycle; a following single flit to (1,0) routes south (2).
- ROUTE_CHECK_EN: a body flit at the head in IDLE → popped, out_valid stays 0, drop_count 0→1; a subsequent single flit is forwarded normally.
